// File: rtl/tsense_poll_ctrl.sv
// rtl/tsense_poll_ctrl.sv - LM07 temperature sensor poll controller
//
// Purpose: reads 16-bit words from an LM07 serial temperature sensor, either
// on demand (req) or from a free-running auto-poll timer (period), and flags
// an over-temperature alarm against a signed threshold.
//
// Ports:
//   SYSCLK      in   system clock, all state changes on its rising edge
//   RSTN        in   asynchronous active-low reset
//   req         in   on-demand read request, sampled every edge
//   period[7:0] in   auto-poll interval in units of 16 clocks, 0 = off
//   thresh[12:0]in   signed alarm threshold for temp_data[15:3]
//   SIO         in   serial data from the sensor
//   CS          out  active-low sensor chip select (registered)
//   SCK         out  sensor serial clock (registered, idles low)
//   temp_data   out  last captured sensor word
//   data_valid  out  one-cycle pulse when temp_data updates
//   src         out  1 = completed read served a demand request
//   busy        out  high whenever a read cycle is in progress
//   alarm       out  signed temp_data[15:3] >= thresh, updated per read
module tsense_poll_ctrl (
  input  logic        SYSCLK,
  input  logic        RSTN,
  input  logic        req,
  input  logic [7:0]  period,
  input  logic [12:0] thresh,
  input  logic        SIO,
  output logic        CS,
  output logic        SCK,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        src,
  output logic        busy,
  output logic        alarm
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] temp_q, temp_d;
  logic        dv_q, dv_d;
  logic        src_q, src_d;
  logic        src_lat_q, src_lat_d;
  logic        alarm_q, alarm_d;
  logic        pend_dem_q, pend_dem_d;
  logic        pend_tmr_q, pend_tmr_d;
  logic [11:0] tmr_q, tmr_d;
  logic [11:0] tmr_limit;
  logic        tick;
  logic        start;
  logic [1:0]  shift_ph;

  // Auto-poll timer: terminal count is period*16-1, so a tick every
  // period*16 clocks. period=0 parks the counter at zero.
  assign tmr_limit = {period, 4'h0} - 12'd1;
  assign tick      = (period != 8'd0) && (tmr_q >= tmr_limit);

  always_comb begin
    tmr_d = tmr_q + 12'd1;
    if ((period == 8'd0) || tick) begin
      tmr_d = 12'd0;
    end
  end

  // Pending flags: a dispatch from IDLE consumes both, but a request or
  // tick arriving on that same edge re-arms its flag so nothing is lost.
  assign start      = (state_q == ST_IDLE) && (pend_dem_q || pend_tmr_q);
  assign pend_dem_d = (pend_dem_q && !start) || req;
  assign pend_tmr_d = (pend_tmr_q && !start) || tick;

  // Position within the 4-cycle SCK period for the edge being computed;
  // the SETUP->SHIFT edge is position 0 (SCK rises, SIO sampled).
  assign shift_ph = cnt_q[1:0] + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    shift_d   = shift_q;
    temp_d    = temp_q;
    dv_d      = 1'b0;
    src_d     = src_q;
    src_lat_d = src_lat_q;
    alarm_d   = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          cnt_d     = 6'd0;
          cs_d      = 1'b0;
          src_lat_d = pend_dem_q;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 6'd1) begin
          state_d = ST_SHIFT;
          cnt_d   = 6'd0;
          sck_d   = 1'b1;
          shift_d = {shift_q[14:0], SIO};
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 6'd63) begin
          // End of the 16th low phase: release the sensor and publish.
          state_d = ST_HOLD;
          cnt_d   = 6'd0;
          cs_d    = 1'b1;
          sck_d   = 1'b0;
          temp_d  = shift_q;
          dv_d    = 1'b1;
          src_d   = src_lat_q;
          alarm_d = ($signed(shift_q[15:3]) >= $signed(thresh));
        end else begin
          cnt_d = cnt_q + 6'd1;
          sck_d = ~shift_ph[1];
          if (shift_ph == 2'd0) begin
            shift_d = {shift_q[14:0], SIO};
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == 6'd3) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      shift_q    <= 16'd0;
      temp_q     <= 16'd0;
      dv_q       <= 1'b0;
      src_q      <= 1'b0;
      src_lat_q  <= 1'b0;
      alarm_q    <= 1'b0;
      pend_dem_q <= 1'b0;
      pend_tmr_q <= 1'b0;
      tmr_q      <= 12'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      shift_q    <= shift_d;
      temp_q     <= temp_d;
      dv_q       <= dv_d;
      src_q      <= src_d;
      src_lat_q  <= src_lat_d;
      alarm_q    <= alarm_d;
      pend_dem_q <= pend_dem_d;
      pend_tmr_q <= pend_tmr_d;
      tmr_q      <= tmr_d;
    end
  end

  assign CS         = cs_q;
  assign SCK        = sck_q;
  assign temp_data  = temp_q;
  assign data_valid = dv_q;
  assign src        = src_q;
  assign busy       = (state_q != ST_IDLE);
  assign alarm      = alarm_q;

endmodule
